node_port_arbiter: RTL and testbench
====================================

// Module: node_port_arbiter
// PURPOSE
// - Shares one node_controller routing engine between the node's three inbound ports:
//   00 = ring dir A, 01 = ring dir B, 10 = local injection.
// - Round-robin grants one 32-bit instruction at a time and pulses the controller.
// - Captures the controller's registered 2-bit route.
// - Forwards the instruction to the selected outbound port with a valid/ready handshake.
// PARAMETERS
// - DATA_WIDTH  32  instruction width; bits [31:29] dest node, [28:26] origin node
// - TIMEOUT     16  SEND-state wait cycles before stall_alarm asserts (>=1)
// PORTS
// - clk              in   1     single clock, all state on posedge
// - rst_n            in   1     asynchronous, active-low reset
// - in_valid         in   3     per-inbound-port request, bit i = port i
// - in_data          in   3*DW  port i at [i*DW +: DW]
// - in_ready         out  3     one-hot accept, bit i = port i
// - ctl_enable       out  1     to node_controller.controller_enable
// - ctl_source_port  out  2     to node_controller.source_port
// - ctl_instruction  out  DW    to node_controller.instruction_in
// - ctl_route        in   2     from node_controller.enable (registered in controller)
// - out_valid        out  3     one-hot by route, bit r = outbound port r
// - out_data         out  DW    held instruction
// - out_ready        in   3     per-outbound-port ready
// - busy             out  1     high in any state except IDLE
// - stall_alarm      out  1     SEND wait count reached TIMEOUT
// - route_err        out  1     1-cycle pulse; captured route was 2'b11, packet dropped
// BEHAVIOUR
// - Reset: FSM=IDLE, held packet discarded, rr_last=2 (port 0 highest priority).
//   All outputs 0; data/source registers 0; wait counter 0.
// - FSM IDLE -> ROUTE -> CAPTURE -> SEND -> IDLE.
// - IDLE, arbitration:
//   - Scan from (rr_last+1) mod 3 upward, wrapping; first set in_valid bit wins.
//   - in_ready[winner]=1 combinationally that cycle only.
//   - Latch in_data[winner] into pkt_q and winner into src_q; rr_last<=winner; -> ROUTE.
//   - No in_valid: in_ready=0, stay in IDLE.
// - ROUTE: ctl_enable=1 for exactly this cycle; the controller registers the route at its end.
//   ctl_source_port=src_q and ctl_instruction=pkt_q, held constant ROUTE through SEND.
// - CAPTURE: route_q<=ctl_route.
//   - ctl_route==2'b11: route_err pulse, packet dropped, -> IDLE.
//   - Otherwise -> SEND.
// - SEND: out_valid[route_q]=1, out_data=pkt_q.
//   - On out_ready[route_q]: transfer this cycle; -> IDLE; wait counter cleared.
//   - Otherwise wait counter increments, saturating at TIMEOUT.
//   - stall_alarm = (counter==TIMEOUT) while in SEND; the packet stays held, never dropped.
// - Latency: accept at cycle N, ctl_enable at N+1, out_valid first at N+3.
//   Peak throughput is 1 packet per 4 cycles; no new accept until SEND completes.
// - ctl_enable=0 outside ROUTE, so the controller's enable output keeps its last value.
// - Boundaries:
//   - in_valid deasserting after accept has no effect on the held packet.
//   - out_ready on a non-selected port is ignored.
//   - All three in_valid high, back to back, are granted 0,1,2,0,...
//   - An async reset in any state aborts immediately; no out_valid glitch.
// TESTING
// - Reset, then in_valid=3'b100 (dest 5, origin 0) ->
//   in_ready=100; ctl_enable at +1 with src=10; route 01 out_valid=010 at +3.
// - in_valid=3'b111 held, out_ready=111 -> grant order 0,1,2,0;
//   each grant 4 cycles apart.
// - Port 0, dest==NODE_IP, controller returns 10 -> out_valid=100;
//   out_ready=100 withheld 20 cycles -> stall_alarm from SEND cycle 17, data held.
// - Forced ctl_route=11 -> route_err one cycle; FSM back in IDLE; no out_valid.
// - rst_n low during SEND -> out_valid=0 immediately;
//   after release, rr restarts at port 0.

Source files
------------

// File: rtl/node_port_arbiter.sv
// Round-robin arbiter sharing one node_controller between the two ring inbound
// ports and local injection; forwards each packet to the routed outbound port.
module node_port_arbiter #(
    parameter int DATA_WIDTH = 32,
    parameter int TIMEOUT    = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [2:0]              in_valid,
    input  logic [3*DATA_WIDTH-1:0] in_data,
    output logic [2:0]              in_ready,
    output logic                    ctl_enable,
    output logic [1:0]              ctl_source_port,
    output logic [DATA_WIDTH-1:0]   ctl_instruction,
    input  logic [1:0]              ctl_route,
    output logic [2:0]              out_valid,
    output logic [DATA_WIDTH-1:0]   out_data,
    input  logic [2:0]              out_ready,
    output logic                    busy,
    output logic                    stall_alarm,
    output logic                    route_err
);

    localparam int CW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        IDLE,
        ROUTE,
        CAPTURE,
        SEND
    } state_t;

    state_t                state_q, state_d;
    logic [DATA_WIDTH-1:0] pkt_q;
    logic [1:0]            src_q;
    logic [1:0]            rr_last_q;
    logic [1:0]            route_q;
    logic [CW-1:0]         wait_q;

    logic                  grant;
    logic [1:0]            winner;
    logic [1:0]            scan;
    logic                  send_done;

    function automatic logic [1:0] next_port(input logic [1:0] p);
        return (p == 2'd2) ? 2'd0 : p + 2'd1;
    endfunction

    // Scan starts one past the last winner so every requester is served within three grants.
    // NOTE: every variable written here gets a default first, otherwise a path that skips
    // an assignment would infer a latch.
    always_comb begin
        grant  = 1'b0;
        winner = 2'd0;
        scan   = next_port(rr_last_q);
        for (int k = 0; k < 3; k++) begin
            if (!grant && in_valid[scan]) begin
                grant  = 1'b1;
                winner = scan;
            end
            scan = next_port(scan);
        end
    end

    assign send_done = (state_q == SEND) && out_ready[route_q];

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (grant) state_d = ROUTE;
            ROUTE:   state_d = CAPTURE;
            CAPTURE: state_d = (ctl_route == 2'b11) ? IDLE : SEND;
            SEND:    if (send_done) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples
    // the pre-edge values of the others.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pkt_q     <= '0;
            src_q     <= 2'd0;
            rr_last_q <= 2'd2;
            route_q   <= 2'd0;
            wait_q    <= '0;
        end else begin
            if (state_q == IDLE && grant) begin
                pkt_q     <= in_data[winner*DATA_WIDTH +: DATA_WIDTH];
                src_q     <= winner;
                rr_last_q <= winner;
            end
            if (state_q == CAPTURE) route_q <= ctl_route;
            // Counter saturates so the alarm stays asserted until the packet leaves.
            if (state_q != SEND || send_done) wait_q <= '0;
            else if (wait_q != CW'(TIMEOUT))  wait_q <= wait_q + 1'b1;
        end
    end

    assign in_ready        = (state_q == IDLE && grant) ? (3'b001 << winner) : 3'b000;
    assign ctl_enable      = (state_q == ROUTE);
    assign ctl_source_port = src_q;
    assign ctl_instruction = pkt_q;
    assign out_valid       = (state_q == SEND) ? (3'b001 << route_q) : 3'b000;
    assign out_data        = pkt_q;
    assign busy            = (state_q != IDLE);
    assign stall_alarm     = (state_q == SEND) && (wait_q == CW'(TIMEOUT));
    assign route_err       = (state_q == CAPTURE) && (ctl_route == 2'b11);

endmodule

// File: tb/tb_node_port_arbiter.sv
// Bench for node_port_arbiter: a transaction-level model checked every cycle plus
// directed scenarios with literal expectations; a stand-in controller supplies routes.
module tb_node_port_arbiter;

    localparam int         DW      = 32;
    localparam int         TO      = 16;
    localparam logic [2:0] NODE_IP = 3'd3;

    logic            clk;
    logic            rst_n;
    logic [2:0]      in_valid;
    logic [3*DW-1:0] in_data;
    logic [2:0]      in_ready;
    logic            ctl_enable;
    logic [1:0]      ctl_source_port;
    logic [DW-1:0]   ctl_instruction;
    logic [1:0]      ctl_route;
    logic [2:0]      out_valid;
    logic [DW-1:0]   out_data;
    logic [2:0]      out_ready;
    logic            busy;
    logic            stall_alarm;
    logic            route_err;
    logic [1:0]      route_cfg;

    int n_checks = 0;
    int n_errors = 0;

    node_port_arbiter #(.DATA_WIDTH(DW), .TIMEOUT(TO)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .ctl_enable(ctl_enable), .ctl_source_port(ctl_source_port),
        .ctl_instruction(ctl_instruction), .ctl_route(ctl_route),
        .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
        .busy(busy), .stall_alarm(stall_alarm), .route_err(route_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Controller stand-in: registers a route when enabled; packets for this node go local.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n)          ctl_route <= 2'b00;
        else if (ctl_enable) ctl_route <= (ctl_instruction[31:29] == NODE_IP) ? 2'b10 : route_cfg;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int model_winner(input logic [2:0] v, input logic [1:0] last);
        for (int k = 0; k < 3; k++) begin
            int p = (int'(last) + 1 + k) % 3;
            if (v[p]) return p;
        end
        return -1;
    endfunction

    // Model: a packet's life is counted in cycles since acceptance.
    bit          m_active;
    int          m_age;
    int          m_wait;
    logic [31:0] m_pkt;
    logic [1:0]  m_src, m_route, m_last;

    always @(negedge clk) begin
        if (!rst_n) begin
            m_active = 0; m_age = 0; m_wait = 0; m_pkt = '0;
            m_src = 2'd0; m_route = 2'd0; m_last = 2'd2;
            check("rst_out_valid", out_valid, 3'b000);
            check("rst_in_ready", in_ready, 3'b000);
            check("rst_busy", busy, 1'b0);
            check("rst_ctl_enable", ctl_enable, 1'b0);
        end else begin
            int         w;
            logic [2:0] e_in_ready, e_out_valid;
            logic       e_en, e_err, e_stall;
            e_in_ready = 3'b000; e_out_valid = 3'b000;
            e_en = 1'b0; e_err = 1'b0; e_stall = 1'b0;
            w = model_winner(in_valid, m_last);
            if (!m_active) begin
                if (w >= 0) e_in_ready = 3'b001 << w;
            end else if (m_age == 1) begin
                e_en = 1'b1;
            end else if (m_age == 2) begin
                e_err = (ctl_route == 2'b11);
            end else begin
                e_out_valid = 3'b001 << m_route;
                e_stall     = (m_wait == TO);
            end
            check("m_in_ready", in_ready, e_in_ready);
            check("m_ctl_enable", ctl_enable, e_en);
            check("m_route_err", route_err, e_err);
            check("m_out_valid", out_valid, e_out_valid);
            check("m_stall_alarm", stall_alarm, e_stall);
            check("m_busy", busy, m_active);
            if (m_active) begin
                check("m_ctl_source_port", ctl_source_port, m_src);
                check("m_ctl_instruction", ctl_instruction, m_pkt);
                if (m_age >= 3) check("m_out_data", out_data, m_pkt);
            end
            // Advance the model across the coming clock edge.
            if (!m_active) begin
                if (w >= 0) begin
                    m_active = 1; m_age = 1;
                    m_pkt = in_data[w*DW +: DW];
                    m_src = 2'(w); m_last = 2'(w);
                end
            end else if (m_age == 1) begin
                m_age = 2;
            end else if (m_age == 2) begin
                if (ctl_route == 2'b11) m_active = 0;
                else begin m_route = ctl_route; m_age = 3; m_wait = 0; end
            end else begin
                if (out_ready[m_route]) m_active = 0;
                else if (m_wait < TO)   m_wait++;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    logic [DW-1:0] pkt_a, pkt_b;
    int            g_port[$];
    int            g_cyc[$];
    int            exp_order[4] = '{0, 1, 2, 0};

    initial begin
        rst_n = 1'b0; in_valid = 3'b000; in_data = '0; out_ready = 3'b000; route_cfg = 2'b00;
        repeat (2) @(posedge clk);
        #1;
        check("reset_busy", busy, 1'b0);
        check("reset_ctl_instruction", ctl_instruction, 32'h0);
        check("reset_ctl_source_port", ctl_source_port, 2'b00);
        check("reset_stall_alarm", stall_alarm, 1'b0);
        check("reset_route_err", route_err, 1'b0);
        rst_n = 1'b1;
        step();

        // Local injection, dest 5 origin 0, routed to port 1.
        pkt_a = {3'd5, 3'd0, 26'h0ABCDE};
        in_data[2*DW +: DW] = pkt_a; in_valid = 3'b100; route_cfg = 2'b01;
        #1 check("t1_in_ready", in_ready, 3'b100);
        step(); in_valid = 3'b000;
        #1;
        check("t1_ctl_enable", ctl_enable, 1'b1);
        check("t1_ctl_source_port", ctl_source_port, 2'b10);
        check("t1_ctl_instruction", ctl_instruction, pkt_a);
        step();
        check("t1_capture_no_enable", ctl_enable, 1'b0);
        check("t1_capture_no_valid", out_valid, 3'b000);
        step(); out_ready = 3'b101;
        #1;
        check("t1_out_valid", out_valid, 3'b010);
        check("t1_out_data", out_data, pkt_a);
        step();
        check("t1_other_ready_ignored", out_valid, 3'b010);
        out_ready = 3'b010;
        step();
        check("t1_done_busy", busy, 1'b0);
        out_ready = 3'b000;

        // All ports requesting, all outbound ready: grants rotate every 4 cycles.
        in_data = {32'h4000_0002, 32'h4000_0001, 32'h4000_0000};
        in_valid = 3'b111; out_ready = 3'b111; route_cfg = 2'b00;
        for (int c = 0; c < 16; c++) begin
            #1;
            for (int p = 0; p < 3; p++)
                if (in_ready[p]) begin g_port.push_back(p); g_cyc.push_back(c); end
            step();
        end
        in_valid = 3'b000;
        check("t2_grant_count", g_port.size(), 4);
        for (int i = 0; i < g_port.size() && i < 4; i++) begin
            check("t2_grant_port", g_port[i], exp_order[i]);
            if (i > 0) check("t2_grant_spacing", g_cyc[i] - g_cyc[i-1], 4);
        end
        step(); out_ready = 3'b000;

        // Packet for this node routed local; outbound withheld 20 cycles.
        pkt_b = {NODE_IP, 3'd1, 26'h0001234};
        in_data[0 +: DW] = pkt_b; in_valid = 3'b001; route_cfg = 2'b01;
        #1 check("t3_in_ready", in_ready, 3'b001);
        step(); in_valid = 3'b000;
        step();
        step();
        for (int k = 1; k <= 20; k++) begin
            check("t3_out_valid", out_valid, 3'b100);
            check("t3_stall_alarm", stall_alarm, (k >= 17));
            check("t3_out_data_held", out_data, pkt_b);
            step();
        end
        out_ready = 3'b100;
        #1 check("t3_still_alarm", stall_alarm, 1'b1);
        step();
        check("t3_done_busy", busy, 1'b0);
        check("t3_alarm_clear", stall_alarm, 1'b0);
        out_ready = 3'b000;

        // Controller returns the invalid route: one-cycle error, packet dropped.
        in_data[DW +: DW] = {3'd6, 3'd2, 26'h0000055}; in_valid = 3'b010; route_cfg = 2'b11;
        #1 check("t4_in_ready", in_ready, 3'b010);
        step(); in_valid = 3'b000;
        step();
        check("t4_route_err", route_err, 1'b1);
        check("t4_no_out_valid", out_valid, 3'b000);
        step();
        check("t4_route_err_gone", route_err, 1'b0);
        check("t4_back_idle", busy, 1'b0);
        check("t4_no_out_valid_after", out_valid, 3'b000);

        // Reset during SEND, then round-robin restarts at port 0.
        in_data[0 +: DW] = {3'd7, 3'd0, 26'h0000099}; in_valid = 3'b001; route_cfg = 2'b00;
        #1 check("t5_in_ready", in_ready, 3'b001);
        step(); in_valid = 3'b000;
        step();
        step();
        check("t5_out_valid", out_valid, 3'b001);
        #1 rst_n = 1'b0;
        #1;
        check("t5_reset_out_valid", out_valid, 3'b000);
        check("t5_reset_busy", busy, 1'b0);
        @(negedge clk);
        step(); rst_n = 1'b1;
        in_valid = 3'b111;
        #1 check("t5_rr_restart", in_ready, 3'b001);
        in_valid = 3'b000; out_ready = 3'b111;
        repeat (6) step();
        check("t5_final_idle", busy, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
